// File: rtl/vend_dispenser_pkg.sv
// vend_pkg: FSM state type and field widths shared by the vend_dispenser output stage
package vend_pkg;
    localparam int GOODS_W  = 2;
    localparam int CHANGE_W = 2;
    localparam int SLOTS    = 4;
    typedef enum logic [2:0] {IDLE, VEND, EJECT, WAIT_DET, GAP, FAULT} state_t;
endpackage

// File: rtl/vend_dispenser_pulse_timer.sv
// pulse_timer: 8-bit down-counter; expired flags the last cycle of an interval of n cycles
module pulse_timer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] n,
    output logic       expired
);
    logic [7:0] cnt_q;
    // reload on request, otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else if (load) cnt_q <= n;
        else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
    end
    assign expired = cnt_q == 8'd1;
endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser: drives slot motor then coin ejector per vend; VEND_DISP_PEND_EN adds a one-entry pending buffer
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sell,
    input  logic [GOODS_W-1:0]  goods,
    input  logic [CHANGE_W-1:0] change,
    input  logic                coin_det,
    input  logic                fault_clr,
    output logic [SLOTS-1:0]    motor,
    output logic                eject,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic                overflow
);
    localparam logic [7:0] PULSE_N   = 8'(PULSE_CYC);
    localparam logic [7:0] GAP_N     = 8'(GAP_CYC);
    localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic [GOODS_W-1:0]  slot_q, slot_d;
    logic [CHANGE_W-1:0] cnt_q, cnt_d;
    logic                seen_q, seen_d;
    logic                ld, expired, fin, done_d, drop;
    logic [7:0]          ld_n;
    logic                pend_v;
    logic [GOODS_W-1:0]  pend_goods;
    logic [CHANGE_W-1:0] pend_change;

    pulse_timer u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (ld),
        .n       (ld_n),
        .expired (expired)
    );

`ifdef VEND_DISP_PEND_EN
    localparam bit PEND_EN = 1'b1;
    // one-entry pending buffer: filled by a sell while busy, drained when a job completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_v      <= 1'b0;
            pend_goods  <= '0;
            pend_change <= '0;
        end else if (state_q == FAULT && fault_clr) begin
            pend_v <= 1'b0;
        end else if (sell && state_q != IDLE && state_q != FAULT && !pend_v && !fin) begin
            pend_v      <= 1'b1;
            pend_goods  <= goods;
            pend_change <= change;
        end else if (fin) begin
            pend_v <= 1'b0;
        end
    end
`else
    localparam bit PEND_EN = 1'b0;
    assign pend_v      = 1'b0;
    assign pend_goods  = '0;
    assign pend_change = '0;
`endif

    // next state, shared-timer reload and request accept/drop decisions
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        ld      = 1'b0;
        ld_n    = PULSE_N;
        fin     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (sell) begin
                state_d = VEND;
                slot_d  = goods;
                cnt_d   = change;
                ld      = 1'b1;
            end
            VEND: if (expired) begin
                if (cnt_q == '0) fin = 1'b1;
                else begin
                    state_d = EJECT;
                    seen_d  = 1'b0;
                    ld      = 1'b1;
                end
            end
            EJECT: begin
                seen_d = seen_q | coin_det;
                if (expired) begin
                    state_d = seen_d ? GAP : WAIT_DET;
                    ld      = 1'b1;
                    ld_n    = seen_d ? GAP_N : TIMEOUT_N;
                end
            end
            WAIT_DET: if (coin_det) begin
                state_d = GAP;
                ld      = 1'b1;
                ld_n    = GAP_N;
            end else if (expired) begin
                state_d = FAULT;
            end
            GAP: if (expired) begin
                cnt_d = cnt_q - CHANGE_W'(1);
                if (cnt_d == '0) fin = 1'b1;
                else begin
                    state_d = EJECT;
                    seen_d  = 1'b0;
                    ld      = 1'b1;
                end
            end
            FAULT: if (fault_clr) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (pend_v) begin
                state_d = VEND;
                slot_d  = pend_goods;
                cnt_d   = pend_change;
                ld      = 1'b1;
                ld_n    = PULSE_N;
            end else if (PEND_EN && sell) begin
                state_d = VEND;
                slot_d  = goods;
                cnt_d   = change;
                ld      = 1'b1;
                ld_n    = PULSE_N;
            end
        end
        drop = sell && state_q != IDLE && (state_q == FAULT ? !fault_clr : !(PEND_EN && !pend_v));
    end

    // state register and registered drives; reset drops every actuator at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            motor    <= '0;
            eject    <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            motor    <= (state_d == VEND) ? (SLOTS'(1) << slot_d) : '0;
            eject    <= state_d == EJECT;
            done     <= done_d;
            overflow <= !fault_clr && (overflow || drop);
        end
    end

    assign busy  = state_q != IDLE;
    assign fault = state_q == FAULT;
endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: directed scenarios checked every cycle against a job-timeline model
module tb_vend_dispenser;
    localparam int LEN = 48;
    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 16;
`ifdef VEND_DISP_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sell = 1'b0;
    logic [1:0] goods = '0;
    logic [1:0] change = '0;
    logic       coin_det = 1'b0;
    logic       fault_clr = 1'b0;
    logic [3:0] motor;
    logic       eject, busy, done, fault, overflow;
    logic [8:0] outs;

    int tests = 0;
    int fails = 0;

    bit         sell_a[LEN];
    logic [1:0] goods_a[LEN];
    logic [1:0] change_a[LEN];
    bit         det_a[LEN];
    bit         clr_a[LEN];

    logic [3:0] em[LEN];
    bit         ee[LEN], eb[LEN], ed[LEN], ef[LEN], eo[LEN];
    logic [3:0] gm[LEN];
    logic       ge[LEN], gb[LEN], gd[LEN], gf[LEN], gov[LEN];

    vend_dispenser dut (
        .clk       (clk),
        .rstn      (rstn),
        .sell      (sell),
        .goods     (goods),
        .change    (change),
        .coin_det  (coin_det),
        .fault_clr (fault_clr),
        .motor     (motor),
        .eject     (eject),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .overflow  (overflow)
    );

    assign outs = {motor, eject, busy, done, fault, overflow};

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic bit det(int i);
        return (i >= 0 && i < LEN) ? det_a[i] : 1'b0;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < LEN; i++) begin
            sell_a[i] = 0; goods_a[i] = '0; change_a[i] = '0; det_a[i] = 0; clr_a[i] = 0;
        end
    endtask

    // walks each job as a timeline: motor window, then per coin an eject window,
    // an optional sensor wait, and a gap; sells seen while busy fill the buffer or are dropped
    task automatic build_model();
        int c, s, n, w, e, x, g, ch, pg, pc;
        bit pv, seen, flt, chain;
        bit drop[LEN];
        for (int i = 0; i < LEN; i++) begin
            em[i] = '0; ee[i] = 0; eb[i] = 0; ed[i] = 0; ef[i] = 0; eo[i] = 0; drop[i] = 0;
        end
        c = 0; pv = 0; pg = 0; pc = 0;
        while (c < LEN) begin
            if (!sell_a[c]) begin
                c++;
                continue;
            end
            s = c; g = int'(goods_a[c]); ch = int'(change_a[c]); chain = 1;
            while (chain) begin
                chain = 0;
                for (int i = s + 1; i <= s + P; i++) if (i < LEN) em[i] = 4'(1 << g);
                n = s + P + 1;
                flt = 0;
                for (int j = 0; j < ch && !flt; j++) begin
                    seen = 0;
                    for (int i = 0; i < P; i++) begin
                        if (n + i < LEN) ee[n + i] = 1;
                        seen |= det(n + i);
                    end
                    n += P;
                    if (!seen) begin
                        w = -1;
                        for (int i = 0; i < T && w < 0; i++) if (det(n + i)) w = n + i;
                        if (w < 0) begin
                            flt = 1;
                            n += T;
                        end else n = w + 1;
                    end
                    if (!flt) n += G;
                end
                e = n;
                for (int i = s + 1; i < e && i < LEN; i++) begin
                    eb[i] = 1;
                    if (sell_a[i]) begin
                        if (PEND && !pv) begin
                            pv = 1; pg = int'(goods_a[i]); pc = int'(change_a[i]);
                        end else drop[i] = 1;
                    end
                end
                if (flt) begin
                    x = e;
                    while (x < LEN - 1 && !clr_a[x]) x++;
                    for (int i = e; i <= x && i < LEN; i++) begin
                        ef[i] = 1; eb[i] = 1;
                        if (sell_a[i] && !clr_a[i]) drop[i] = 1;
                    end
                    pv = 0;
                    c = x + 1;
                end else begin
                    if (e < LEN) ed[e] = 1;
                    if (pv) begin
                        pv = 0; s = e - 1; g = pg; ch = pc; chain = 1;
                    end else c = e;
                end
            end
        end
        for (int i = 0; i + 1 < LEN; i++) eo[i + 1] = !clr_a[i] && (eo[i] || drop[i]);
    endtask

    task automatic do_reset();
        sell = 0; goods = '0; change = '0; coin_det = 0; fault_clr = 0; rstn = 0;
        @(negedge clk);
        chk("reset_outputs", 16'(outs), 16'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic run_scen(string nm);
        build_model();
        do_reset();
        for (int c = 0; c < LEN; c++) begin
            @(posedge clk);
            #1;
            sell = sell_a[c]; goods = goods_a[c]; change = change_a[c];
            coin_det = det_a[c]; fault_clr = clr_a[c];
            @(negedge clk);
            gm[c] = motor; ge[c] = eject; gb[c] = busy; gd[c] = done; gf[c] = fault; gov[c] = overflow;
            chk($sformatf("%s_cyc%0d", nm, c), 16'(outs), 16'({em[c], ee[c], eb[c], ed[c], ef[c], eo[c]}));
        end
        @(posedge clk);
        #1;
        sell = 0; coin_det = 0; fault_clr = 0;
    endtask

    initial begin
        // plain vend, no change
        clear_stim();
        sell_a[2] = 1; goods_a[2] = 2; change_a[2] = 0;
        run_scen("s1");
        chk("s1_motor_first", 16'(gm[3]), 16'h4);
        chk("s1_motor_last", 16'(gm[6]), 16'h4);
        chk("s1_motor_off", 16'(gm[7]), 16'h0);
        chk("s1_done", 16'(gd[7]), 16'h1);
        chk("s1_busy_at_done", 16'(gb[7]), 16'h0);

        // two coins, sensor in cycle 2 of each eject, stray pulses in VEND and GAP
        clear_stim();
        sell_a[2] = 1; goods_a[2] = 1; change_a[2] = 2;
        det_a[4] = 1; det_a[8] = 1; det_a[11] = 1; det_a[14] = 1;
        run_scen("s2");
        chk("s2_motor", 16'(gm[3]), 16'h2);
        chk("s2_eject1_first", 16'(ge[7]), 16'h1);
        chk("s2_eject1_last", 16'(ge[10]), 16'h1);
        chk("s2_gap", 16'(ge[12]), 16'h0);
        chk("s2_eject2_first", 16'(ge[13]), 16'h1);
        chk("s2_done", 16'(gd[19]), 16'h1);
        chk("s2_busy_at_done", 16'(gb[19]), 16'h0);

        // sensor timeout, sell dropped in fault, clear with simultaneous sell
        clear_stim();
        sell_a[2] = 1; goods_a[2] = 0; change_a[2] = 1;
        sell_a[30] = 1; goods_a[30] = 1;
        sell_a[35] = 1; goods_a[35] = 2; clr_a[35] = 1;
        run_scen("s3");
        chk("s3_eject_last", 16'(ge[10]), 16'h1);
        chk("s3_fault_before", 16'(gf[26]), 16'h0);
        chk("s3_fault_rise", 16'(gf[27]), 16'h1);
        chk("s3_ovf_set", 16'(gov[31]), 16'h1);
        chk("s3_fault_cleared", 16'(gf[36]), 16'h0);
        chk("s3_ovf_cleared", 16'(gov[36]), 16'h0);
        chk("s3_idle_after_clr", 16'(gb[36]), 16'h0);

        // second sell during VEND
        clear_stim();
        sell_a[2] = 1; goods_a[2] = 0; change_a[2] = 0;
        sell_a[4] = 1; goods_a[4] = 3; change_a[4] = 1;
        det_a[12] = 1;
        run_scen("s4");
        chk("s4_done1", 16'(gd[7]), 16'h1);
`ifdef VEND_DISP_PEND_EN
        chk("s4_busy_b2b", 16'(gb[7]), 16'h1);
        chk("s4_motor2", 16'(gm[7]), 16'h8);
        chk("s4_done2", 16'(gd[17]), 16'h1);
        chk("s4_no_ovf", 16'(gov[20]), 16'h0);
`else
        chk("s4_busy_at_done", 16'(gb[7]), 16'h0);
        chk("s4_ovf", 16'(gov[5]), 16'h1);
`endif

        // third sell with buffer full; overflow sticky until clear
        clear_stim();
        sell_a[2] = 1; goods_a[2] = 1; change_a[2] = 0;
        sell_a[3] = 1; goods_a[3] = 2; change_a[3] = 0;
        sell_a[4] = 1; goods_a[4] = 3; change_a[4] = 0;
        clr_a[30] = 1;
        run_scen("s5");
        chk("s5_ovf_set", 16'(gov[5]), 16'h1);
        chk("s5_ovf_sticky", 16'(gov[30]), 16'h1);
        chk("s5_ovf_clear", 16'(gov[31]), 16'h0);
`ifdef VEND_DISP_PEND_EN
        chk("s5_ovf_not_yet", 16'(gov[4]), 16'h0);
        chk("s5_motor2", 16'(gm[7]), 16'h4);
        chk("s5_done2", 16'(gd[11]), 16'h1);
`else
        chk("s5_ovf_early", 16'(gov[4]), 16'h1);
`endif

        // asynchronous reset during EJECT, then a fresh vend
        do_reset();
        @(posedge clk);
        #1;
        sell = 1; goods = 1; change = 1;
        @(posedge clk);
        #1;
        sell = 0;
        for (int i = 0; i < 20 && eject !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_eject_reached", 16'(eject), 16'h1);
        #2;
        rstn = 0;
        #1;
        chk("rst_async_outputs", 16'(outs), 16'h0);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        sell = 1; goods = 3; change = 0;
        @(posedge clk);
        #1;
        sell = 0;
        chk("rst_new_motor", 16'(motor), 16'h8);
        chk("rst_new_busy", 16'(busy), 16'h1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_new_done", 16'({motor, done, busy}), 16'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Output stage placed directly downstream of `vending_machine`. It consumes the machine's single-cycle `sell` pulse together with the `goods` selection and the `change` count. It then sequences the physical actuators: a timed pulse on one goods-slot motor, followed by one ejector pulse per change coin, each confirmed by a coin-detect sensor. A timeout on that sensor raises a latched fault.

## Interface
- `PULSE_CYC`, 4: actuator on-time in cycles; legal range 1..255.
- `GAP_CYC`, 2: off-time after each confirmed coin, in cycles; legal range 1..255.
- `TIMEOUT_CYC`, 16: cycles allowed for `coin_det` after an ejector pulse; legal range 1..255.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `sell`  in  1  one-cycle vend request from `vending_machine`.
- `goods`  in  2  slot index 0..3, valid when `sell` is high.
- `change`  in  2  number of change coins to return (0..3), valid when `sell` is high.
- `coin_det`  in  1  ejector sensor; already synchronous; one or more high cycles per coin.
- `fault_clr`  in  1  one-cycle clear for the fault state and the overflow flag.
- `motor`  out  4  one-hot slot motor drive.
- `eject`  out  1  coin ejector drive.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when a job completes normally.
- `fault`  out  1  high while the FSM is in FAULT.
- `overflow`  out  1  sticky; set when a request is dropped.

## Operation
- FSM states: IDLE, VEND, EJECT, WAIT_DET, GAP, FAULT.
- IDLE, `sell`=1: latch `goods` into `slot_q` and `change` into `cnt_q`; go to VEND.
- VEND: `motor[slot_q]`=1 for exactly PULSE_CYC cycles.
  - When it expires and `cnt_q`=0: job complete.
  - When it expires and `cnt_q`>0: go to EJECT.
- EJECT: `eject`=1 for PULSE_CYC cycles. A `coin_det` high in any cycle during EJECT sets the `seen` flag.
  - When it expires with `seen` set: go to GAP.
  - When it expires with `seen` clear: go to WAIT_DET.
- WAIT_DET: `eject`=0.
  - `coin_det`=1: go to GAP.
  - TIMEOUT_CYC cycles pass without `coin_det`: go to FAULT.
- GAP: all drives are 0 for GAP_CYC cycles. Then `cnt_q` decrements by 1.
  - `cnt_q` reaches 0: job complete.
  - Otherwise: go back to EJECT with `seen` cleared.
- Job complete: `done`=1 for one cycle.
  - Pending entry valid: load it and go to VEND.
  - Otherwise: go to IDLE.
- FAULT: all drives are 0; `fault`=1.
  - `fault_clr` returns the FSM to IDLE and clears `cnt_q`, the pending entry, and `overflow`.
  - No `done` pulse is generated.
- `sell` while busy:
  - Pending buffer (see Configuration) empty: the request is captured there.
  - Otherwise: the request is dropped and `overflow` is set.
  - Any `sell` received in FAULT is dropped and sets `overflow`.
- Simultaneous `sell` and `fault_clr` in FAULT: the clear wins and the `sell` is dropped; `overflow` remains clear.
- Extra `coin_det` pulses outside EJECT and WAIT_DET are ignored.

## Timing
- Reset values: all outputs are 0; the FSM is in IDLE; counters, `cnt_q` and the pending entry are cleared.
- Reset asserted mid-job: every actuator drops asynchronously in the same instant.
- `sell` sampled at edge N: `motor` and `busy` go high from cycle N+1. `motor` stays high for cycles N+1..N+PULSE_CYC.
- `eject` rises in the first cycle after VEND ends, with no dead cycle in between.
- `done` is high in the cycle after the last GAP cycle, or the cycle after the last VEND cycle when `change`=0.
  - `busy` is 0 in that same cycle, unless a pending entry loads.
- `motor` and `eject` are registered outputs and are never both high.

## Configuration
- `VEND_DISP_PEND_EN` defined: one-entry pending buffer holding `goods` and `change`. It is loaded by `sell` while busy and drained at job completion.
- `VEND_DISP_PEND_EN` undefined: no buffer. Any `sell` while busy is dropped and sets `overflow`.

## Structure
- Package `vend_pkg` holds:
  - the FSM state enum;
  - `GOODS_W`=2 and `CHANGE_W`=2;
  - a slot-count constant of 4.
- Sub-module `pulse_timer`:
  - 8-bit down-counter, loaded with N;
  - `expired` output asserted on the final count cycle.
- The FSM reuses one `pulse_timer` for the PULSE, GAP and TIMEOUT intervals.

## Test plan
All scenarios use the default parameters.
- `sell` with `goods`=2, `change`=0 -> `motor`=4'b0100 for 4 cycles, then `done` one cycle later; `eject` never rises.
- `sell` with `goods`=1, `change`=2, `coin_det` pulsed in cycle 2 of each EJECT -> 2 ejector pulses of 4 cycles each, separated by a 2-cycle gap; one `done`.
- `change`=1 with no `coin_det` -> `fault`=1 exactly 16 cycles after `eject` falls; `fault_clr` -> IDLE with no `done`.
- Second `sell` (`goods`=3, `change`=1) during VEND:
  - macro on: the second job runs back-to-back and `busy` stays high across both;
  - macro off: the second job is dropped and `overflow`=1.
- Third `sell` while the pending entry is full -> `overflow`=1, and it stays set until `fault_clr`.
- `rstn` low during EJECT -> `eject` and `busy` are 0 immediately; after release, a new `sell` works normally.
